// File: rtl/axi4_stream_pkg.sv
// Shared types and default widths for the AXI4-Stream burst source.
package axi4_stream_pkg;

    localparam int unsigned DATA_SIZE_DEF = 32;
    localparam int unsigned LEN_SIZE_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

endpackage

// File: rtl/axi4_stream_burst_source_if.sv
// Stream payload/handshake bundle between the burst source and its sink.
interface axi4_stream_burst_source_if
    import axi4_stream_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
);

    logic [DATA_SIZE-1:0] write_data;
    logic                 write_data_valid;
    logic                 write_data_ready;
    logic                 write_data_last;

    modport master (
        output write_data,
        output write_data_valid,
        output write_data_last,
        input  write_data_ready
    );

    modport slave (
        input  write_data,
        input  write_data_valid,
        input  write_data_last,
        output write_data_ready
    );

endinterface

// File: rtl/axi4_stream_burst_source.sv
// Emits a burst of incrementing data beats with optional idle gaps between beats.
module axi4_stream_burst_source
    import axi4_stream_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned LEN_SIZE  = LEN_SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_SIZE-1:0]       start_value,
    input  logic [LEN_SIZE-1:0]        burst_len,
    input  logic [LEN_SIZE-1:0]        gap_len,
    axi4_stream_burst_source_if.master stream,
    output logic                       busy,
    output logic                       done
);

    localparam logic [DATA_SIZE-1:0] DATA_ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1};
    localparam logic [LEN_SIZE-1:0]  LEN_ONE  = {{(LEN_SIZE-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [LEN_SIZE-1:0]  len_q, len_d;
    logic [LEN_SIZE-1:0]  gap_q, gap_d;
    logic [LEN_SIZE-1:0]  beat_q, beat_d;
    logic [LEN_SIZE-1:0]  gcnt_q, gcnt_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic [LEN_SIZE-1:0]  beat_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            beat_q  <= '0;
            gcnt_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            beat_q  <= beat_d;
            gcnt_q  <= gcnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Every output is a register; ready only steers next-state values.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        len_d    = len_q;
        gap_d    = gap_q;
        beat_d   = beat_q;
        gcnt_d   = gcnt_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        beat_inc = beat_q + LEN_ONE;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    data_d  = start_value;
                    len_d   = burst_len;
                    gap_d   = gap_len;
                    beat_d  = '0;
                    valid_d = 1'b1;
                    last_d  = (burst_len == '0);
                end
            end
            SEND: begin
                if (valid_q && stream.write_data_ready) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = data_q + DATA_ONE;
                        beat_d = beat_inc;
                        last_d = (beat_inc == len_q);
                        if (gap_q == '0) begin
                            valid_d = 1'b1;
                        end else begin
                            // Counter runs G-1 down to 0, giving exactly G cycles with valid low.
                            state_d = GAP;
                            valid_d = 1'b0;
                            gcnt_d  = gap_q - LEN_ONE;
                        end
                    end
                end
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - LEN_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign stream.write_data       = data_q;
    assign stream.write_data_valid = valid_q;
    assign stream.write_data_last  = last_q;
    assign busy                    = (state_q != IDLE);
    assign done                    = done_q;

endmodule

// File: tb/tb_axi4_stream_burst_source.sv
// Scoreboard bench for axi4_stream_burst_source: directed scenarios plus randomized bursts.
module tb_axi4_stream_burst_source;
    import axi4_stream_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int unsigned   gap;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] start_value = '0;
    logic [LW-1:0] burst_len = '0;
    logic [LW-1:0] gap_len = '0;
    logic          busy;
    logic          done;

    axi4_stream_burst_source_if #(.DATA_SIZE(DW)) ws ();

    axi4_stream_burst_source #(.DATA_SIZE(DW), .LEN_SIZE(LW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_value (start_value),
        .burst_len   (burst_len),
        .gap_len     (gap_len),
        .stream      (ws),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hs_count = 0;
    int          ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready pattern: 0 = always high, 1 = toggling, 2 = random.
    initial begin
        ws.write_data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       ws.write_data_ready = ~ws.write_data_ready;
                2:       ws.write_data_ready = 1'($urandom_range(0, 1));
                default: ws.write_data_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the reference queue on every handshake.
    initial begin
        beat_t         e;
        logic          held = 1'b0;
        logic [DW-1:0] hd = '0;
        logic          hl = 1'b0;
        logic          after_hs = 1'b0;
        logic          pend_done = 1'b0;
        int unsigned   low_cnt = 0;
        int unsigned   cur_gap = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
                after_hs = 1'b0;
                pend_done = 1'b0;
                low_cnt = 0;
                continue;
            end
            if (pend_done) begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("busy_at_done", 64'(busy), 64'd0);
                pend_done = 1'b0;
            end else if (done) begin
                chk("spurious_done", 64'(done), 64'd0);
            end
            if (held) begin
                chk("hold_valid", 64'(ws.write_data_valid), 64'd1);
                chk("hold_data", 64'(ws.write_data), 64'(hd));
                chk("hold_last", 64'(ws.write_data_last), 64'(hl));
                held = 1'b0;
            end
            if (ws.write_data_valid) begin
                if (after_hs) begin
                    chk("gap_cycles", 64'(low_cnt), 64'(cur_gap));
                    after_hs = 1'b0;
                end
                if (ws.write_data_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got data %0h with no beat expected at %0t",
                                 ws.write_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(ws.write_data), 64'(e.data));
                        chk("beat_last", 64'(ws.write_data_last), 64'(e.last));
                        if (e.last) begin
                            pend_done = 1'b1;
                        end else begin
                            after_hs = 1'b1;
                            low_cnt = 0;
                            cur_gap = e.gap;
                        end
                    end
                end else begin
                    held = 1'b1;
                    hd = ws.write_data;
                    hl = ws.write_data_last;
                end
            end else if (after_hs) begin
                low_cnt++;
            end
        end
    end

    // Called just after a rising edge while the DUT is idle; expects acceptance at the next edge.
    task automatic issue(input logic [DW-1:0] sv, input logic [LW-1:0] bl, input logic [LW-1:0] gl);
        beat_t b;
        start = 1'b1;
        start_value = sv;
        burst_len = bl;
        gap_len = gl;
        for (int unsigned i = 0; i <= int'(bl); i++) begin
            b.data = sv + DW'(i);
            b.last = (i == int'(bl));
            b.gap = int'(gl);
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        chk("start_valid", 64'(ws.write_data_valid), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        start = 1'b0;
        start_value = $urandom;
        burst_len = LW'($urandom);
        gap_len = LW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no done within %0d cycles, expected one", budget);
    endtask

    initial begin
        int base;
        int n;
        logic [DW-1:0] sv;

        #1;
        chk("rst_data", 64'(ws.write_data), 64'd0);
        chk("rst_valid", 64'(ws.write_data_valid), 64'd0);
        chk("rst_last", 64'(ws.write_data_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;

        ready_mode = 0;
        issue(32'd10, 8'd0, 8'd0);
        wait_done(20);

        issue(32'd0, 8'd7, 8'd0);
        wait_done(40);

        ready_mode = 1;
        issue(32'd0, 8'd7, 8'd0);
        wait_done(60);

        ready_mode = 0;
        issue(32'hFFFF_FFFE, 8'd3, 8'd2);
        wait_done(60);

        issue($urandom, 8'hFF, 8'd0);
        wait_done(400);

        // Second start while busy, then reset after the third beat is accepted.
        base = hs_count;
        issue(32'd100, 8'd7, 8'd0);
        start = 1'b1;
        start_value = 32'd999;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (hs_count < base + 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("hs_before_reset", 64'(hs_count - base), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid", 64'(ws.write_data_valid), 64'd0);
        chk("abort_last", 64'(ws.write_data_last), 64'd0);
        chk("abort_data", 64'(ws.write_data), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_resume_valid", 64'(ws.write_data_valid), 64'd0);
            chk("no_resume_busy", 64'(busy), 64'd0);
        end
        issue(32'd12345, 8'd2, 8'd1);
        wait_done(40);

        for (int k = 0; k < 25; k++) begin
            ready_mode = $urandom_range(0, 2);
            sv = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            issue(sv, LW'($urandom_range(0, 12)), LW'($urandom_range(0, 3)));
            wait_done(300);
            n = $urandom_range(0, 2);
            if (n > 0) begin
                repeat (n) @(posedge clk);
                #2;
            end
        end

        repeat (5) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/axi4_stream_burst_source.md
AXI4_STREAM_BURST_SOURCE -- requirements
Module: axi4_stream_burst_source

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, stream data width in bits.
REQ-002 SHALL have parameter LEN_SIZE, default 8, width of the burst_len and gap_len inputs.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-006 SHALL have port start_value  input  DATA_SIZE  data of first beat.
REQ-007 SHALL have port burst_len  input  LEN_SIZE  beats minus one (0 = 1 beat).
REQ-008 SHALL have port gap_len  input  LEN_SIZE  idle cycles inserted after each accepted non-last beat.
REQ-009 SHALL have port write_data  output  DATA_SIZE  stream payload.
REQ-010 SHALL have port write_data_valid  output  1  payload valid.
REQ-011 SHALL have port write_data_ready  input  1  downstream accepts.
REQ-012 SHALL have port write_data_last  output  1  marks final beat of burst.
REQ-013 SHALL have port busy  output  1  high outside IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after final handshake.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, GAP.
REQ-016 IDLE: start=1 at an edge SHALL latch start_value, burst_len and gap_len, clear the beat counter, enter SEND; write_data_valid high from the next cycle.
REQ-017 Handshake SHALL be write_data_valid & write_data_ready at a rising edge.
REQ-018 In SEND, write_data_valid SHALL stay high and write_data/write_data_last SHALL stay stable until handshake; valid never drops without handshake.
REQ-019 write_data_ready SHALL NOT combinationally affect any output (all outputs registered).
REQ-020 On non-last handshake: data SHALL increment by 1 modulo 2^DATA_SIZE (all-ones wraps to 0); beat counter +1.
REQ-021 After non-last handshake with latched gap_len=0 SHALL remain in SEND, valid held high: one beat per cycle under continuous ready.
REQ-022 After non-last handshake with gap_len=G>0 SHALL enter GAP, valid low for exactly G cycles, then return to SEND.
REQ-023 write_data_last SHALL be high exactly while beat counter equals latched burst_len.
REQ-024 On last handshake SHALL return to IDLE; valid and last low next cycle; done high for that one cycle only.
REQ-025 start while busy SHALL be ignored, not queued; start in the done cycle (IDLE) SHALL be accepted.
REQ-026 Changes to start_value/burst_len/gap_len after latch SHALL NOT affect the running burst.
REQ-027 burst_len all-ones SHALL produce 2^LEN_SIZE beats; counter SHALL NOT overflow early.

Reset
REQ-028 reset high SHALL asynchronously force IDLE; write_data=0, write_data_valid=0, write_data_last=0, busy=0, done=0, counters 0.
REQ-029 reset mid-burst SHALL abort it with valid dropping immediately; no done pulse; no resume after release.
REQ-030 First start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-031 Package axi4_stream_pkg SHALL hold the FSM state typedef and the DATA_SIZE/LEN_SIZE defaults.
REQ-032 Single module, no sub-modules; the gap counter is inline.

Verification
REQ-033 start_value=10, burst_len=0, gap_len=0, ready=1 -> one beat data 10 with last=1, done one cycle after, busy low.
REQ-034 start_value=0, burst_len=7, gap_len=0, ready=1 -> beats 0..7 on 8 consecutive cycles, last only on 7, one done.
REQ-035 Same burst, ready toggling 1/0 every cycle -> data/last held stable while ready=0; sequence 0..7 intact.
REQ-036 start_value=32'hFFFF_FFFE, burst_len=3, gap_len=2 -> beats FFFF_FFFE, FFFF_FFFF, 0, 1; exactly 2 valid-low cycles between beats.
REQ-037 start pulse while busy, then reset asserted mid-burst after beat 3 of 8 -> second start ignored; valid=0 immediately; no done; start after release begins a fresh burst from the new start_value.
